multi_read_mem: RTL

Parametrised register-file memory with one write port and `ReadPorts` independent read ports. It has an optional registered read stage with write-first bypass, and a hardware clear sequencer that initialises every word after reset or on request. It is the general successor of the dual-read register memory and serves register files, lookup tables and small scratchpads that need N simultaneous reads and a known power-up state.

---
 rtl/multi_read_mem.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multi_read_mem.sv
// multi_read_mem: register-file memory with one write port and ReadPorts
// independent read ports. After reset (or on a clr request) a sequencer
// writes ClearValue to every word while busy is high. Reads are either
// registered with write-first bypass (RegisteredRead=1) or combinational.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_en              global clock enable; low holds all state
//   clr                 request a full re-clear (honoured when not busy)
//   wEn, wAddr, dIN     write port; out-of-range addresses are dropped
//   rEn, rAddr          per-port read enable / packed read addresses
//   dOUT, rValid        per-port packed read data / data-valid
//   busy                clear sequencer active; reads and writes refused

module multi_read_mem_port #(
    parameter int BitWidth             = 8,
    parameter bit RegisteredRead       = 1,
    parameter bit InvertedDisabledDOUT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                rdOk,     // read is legal this cycle
    input  logic                bypass,   // accepted write hits this address
    input  logic [BitWidth-1:0] memWord,
    input  logic [BitWidth-1:0] wData,
    output logic [BitWidth-1:0] dOUT,
    output logic                rValid
);
    localparam logic [BitWidth-1:0] DisVal = {BitWidth{InvertedDisabledDOUT}};

    if (RegisteredRead) begin : gReg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dOUT   <= DisVal;
                rValid <= 1'b0;
            end else if (clk_en) begin
                rValid <= rdOk;
                // write-first: new data is visible at the same edge as the write
                dOUT   <= !rdOk ? DisVal : (bypass ? wData : memWord);
            end
        end
    end else begin : gComb
        // clocking and bypass inputs only matter in the registered variant
        logic unusedInputs;
        assign unusedInputs = &{1'b0, clk, rst_n, clk_en, bypass, wData};
        assign rValid = rdOk;
        assign dOUT   = rdOk ? memWord : DisVal;
    end
endmodule

module multi_read_mem #(
    parameter int                  BitWidth             = 8,
    parameter int                  Depth                = 16,
    parameter int                  ReadPorts            = 2,
    parameter bit                  RegisteredRead       = 1,
    parameter bit                  InvertedDisabledDOUT = 0,
    parameter logic [BitWidth-1:0] ClearValue           = '0,
    localparam int                 AW = (Depth > 2) ? $clog2(Depth) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          clr,
    input  logic                          wEn,
    input  logic [AW-1:0]                 wAddr,
    input  logic [BitWidth-1:0]           dIN,
    input  logic [ReadPorts-1:0]          rEn,
    input  logic [ReadPorts*AW-1:0]       rAddr,
    output logic [ReadPorts*BitWidth-1:0] dOUT,
    output logic [ReadPorts-1:0]          rValid,
    output logic                          busy
);
    typedef enum logic {CLEAR, READY} state_t;

    // one extra bit so Depth itself is representable for range checks
    localparam logic [AW:0]   DepthL   = (AW+1)'(Depth);
    localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

    state_t              state, stateNxt;
    logic [AW-1:0]       cAddr, cAddrNxt;
    logic [BitWidth-1:0] memBuff [Depth];
    logic                ready, wrAccept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cAddr <= '0;
        end else if (clk_en) begin
            state <= stateNxt;
            cAddr <= cAddrNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        cAddrNxt = cAddr;
        case (state)
            CLEAR: begin
                if (cAddr == LastAddr) begin
                    stateNxt = READY;
                    cAddrNxt = '0;
                end else begin
                    cAddrNxt = cAddr + AW'(1);
                end
            end
            READY: if (clr) stateNxt = CLEAR;
            default: stateNxt = CLEAR;
        endcase
    end

    assign ready = (state == READY);
    assign busy  = (state == CLEAR);

    // clr has priority: a write in the same cycle is discarded
    assign wrAccept = ready && wEn && !clr && ({1'b0, wAddr} < DepthL);

    // array intentionally has no reset; the clear sequencer initialises it
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (busy)          memBuff[cAddr] <= ClearValue;
            else if (wrAccept) memBuff[wAddr] <= dIN;
        end
    end

    for (genvar p = 0; p < ReadPorts; p++) begin : gPort
        logic [AW-1:0] ra;
        assign ra = rAddr[p*AW +: AW];

        multi_read_mem_port #(
            .BitWidth            (BitWidth),
            .RegisteredRead      (RegisteredRead),
            .InvertedDisabledDOUT(InvertedDisabledDOUT)
        ) uPort (
            .clk    (clk),
            .rst_n  (rst_n),
            .clk_en (clk_en),
            .rdOk   (ready && rEn[p] && ({1'b0, ra} < DepthL)),
            .bypass (wrAccept && (wAddr == ra)),
            .memWord(memBuff[ra]),
            .wData  (dIN),
            .dOUT   (dOUT[p*BitWidth +: BitWidth]),
            .rValid (rValid[p])
        );
    end
endmodule
